// File: rtl/i2s_tx_scheduler.sv
// Picks or mixes two stereo sources into a small frame FIFO and hands the I2S transmitter one
// coherent frame per word-select period, updated only on the mclk edge where ws is first seen high.
module i2s_tx_scheduler #(
  parameter int d_width     = 24,
  parameter int fifo_depth  = 4,
  parameter int prime_level = 2
) (
  input  logic                        mclk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic                        s0_valid,
  output logic                        s0_ready,
  input  logic signed [d_width-1:0]   s0_l,
  input  logic signed [d_width-1:0]   s0_r,
  input  logic                        s1_valid,
  output logic                        s1_ready,
  input  logic signed [d_width-1:0]   s1_l,
  input  logic signed [d_width-1:0]   s1_r,
  input  logic                        ws,
  output logic signed [d_width-1:0]   l_data_tx,
  output logic signed [d_width-1:0]   r_data_tx,
  output logic [1:0]                  state,
  output logic [$clog2(fifo_depth):0] fifo_level,
  output logic                        underrun,
  output logic [15:0]                 underrun_cnt
);
  localparam int aw = $clog2(fifo_depth);
  localparam int lw = aw + 1;

  typedef enum logic [1:0] {IDLE = 2'b00, PRIME = 2'b01, RUN = 2'b10} state_t;

  state_t               cur;
  logic                 ws_q;
  logic                 ws_rise;
  logic [aw-1:0]        wr_ptr;
  logic [aw-1:0]        rd_ptr;
  logic [2*d_width-1:0] mem [fifo_depth];
  logic                 can_push;
  logic                 push;
  logic                 pop;
  logic [d_width-1:0]   push_l;
  logic [d_width-1:0]   push_r;

  function automatic logic [d_width-1:0] sat_add(input logic [d_width-1:0] a,
                                                 input logic [d_width-1:0] b);
    logic [d_width:0] s;
    s = {a[d_width-1], a} + {b[d_width-1], b};
    if (s[d_width] != s[d_width-1])
      sat_add = s[d_width] ? {1'b1, {(d_width-1){1'b0}}} : {1'b0, {(d_width-1){1'b1}}};
    else
      sat_add = s[d_width-1:0];
  endfunction

  assign ws_rise  = ws & ~ws_q;
  assign can_push = enable && (cur != IDLE) && (fifo_level < lw'(fifo_depth));
  // A frame pushed this cycle is never visible to a pop until the level register sees it.
  assign pop      = enable && (cur == RUN) && ws_rise && (fifo_level != '0);
  assign state    = cur;

  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    push     = 1'b0;
    push_l   = '0;
    push_r   = '0;
    case (mode)
      2'b00: begin
        s0_ready = can_push;
        push     = can_push & s0_valid;
        push_l   = s0_l;
        push_r   = s0_r;
      end
      2'b01: begin
        s1_ready = can_push;
        push     = can_push & s1_valid;
        push_l   = s1_l;
        push_r   = s1_r;
      end
      2'b10: begin
        s0_ready = can_push & s0_valid & s1_valid;
        s1_ready = can_push & s0_valid & s1_valid;
        push     = can_push & s0_valid & s1_valid;
        push_l   = sat_add(s0_l, s1_l);
        push_r   = sat_add(s0_r, s1_r);
      end
      default: begin
        // Mute: src0 paced as normal but replaced by silence, src1 drained and dropped.
        s0_ready = can_push;
        s1_ready = can_push;
        push     = can_push & s0_valid;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (push)
      mem[wr_ptr] <= {push_l, push_r};
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cur          <= IDLE;
      ws_q         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      l_data_tx    <= '0;
      r_data_tx    <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      ws_q     <= ws;
      underrun <= 1'b0;
      if (!enable) begin
        cur        <= IDLE;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        l_data_tx  <= '0;
        r_data_tx  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        fifo_level <= fifo_level + lw'(push) - lw'(pop);
        case (cur)
          IDLE:  cur <= PRIME;
          PRIME: if (fifo_level >= lw'(prime_level)) cur <= RUN;
          RUN: begin
            if (ws_rise) begin
              if (pop) begin
                l_data_tx <= mem[rd_ptr][2*d_width-1:d_width];
                r_data_tx <= mem[rd_ptr][d_width-1:0];
              end else begin
                l_data_tx <= '0;
                r_data_tx <= '0;
                underrun  <= 1'b1;
                if (underrun_cnt != 16'hFFFF)
                  underrun_cnt <= underrun_cnt + 16'd1;
                cur <= PRIME;
              end
            end
          end
          default: cur <= IDLE;
        endcase
      end
    end
  end
endmodule
